// File: rtl/sap_exec_core.sv
// Execution core of the SAP-style computer: program counter, add/subtract ALU
// with latched flags, and the microstep-driven control unit for the bus strobes.
module sap_exec_core (
  input  logic       clk,
  input  logic       clr,
  input  logic [3:0] opcode,
  input  logic [3:0] ir_addr,
  input  logic [7:0] a_val,
  input  logic [7:0] b_val,
  output logic [3:0] pc_bus,
  output logic [3:0] pc_val,
  output logic [7:0] alu_bus,
  output logic       cf,
  output logic       zf,
  output logic [2:0] step,
  output logic       hlt,
  output logic       marwa,
  output logic       ramwa,
  output logic       ramoa,
  output logic       inregoa,
  output logic       inregwa,
  output logic       awa,
  output logic       aoa,
  output logic       sumout,
  output logic       sub,
  output logic       bwa,
  output logic       outregwa,
  output logic       pcinc,
  output logic       pcoe,
  output logic       pcjmp,
  output logic       flagsin
);

  typedef enum logic [2:0] {T0 = 3'd0, T1 = 3'd1, T2 = 3'd2, T3 = 3'd3, T4 = 3'd4} step_t;

  step_t      step_q;
  step_t      step_next;
  logic [3:0] pc;
  logic [8:0] sum9;
  logic [7:0] b_op;

  // Subtraction is two's complement: invert B and feed sub in as carry-in.
  assign b_op    = sub ? ~b_val : b_val;
  assign sum9    = {1'b0, a_val} + {1'b0, b_op} + {8'd0, sub};
  assign alu_bus = sumout ? sum9[7:0] : 8'h00;
  assign pc_val  = pc;
  assign pc_bus  = pcoe ? pc : 4'h0;
  assign step    = step_q;

  // Microstep advances on the falling edge so strobes settle before the rising edge.
  always_ff @(negedge clk or negedge clr) begin
    if (!clr)
      step_q <= T0;
    else
      step_q <= step_next;
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      pc <= 4'h0;
    end else if (!hlt) begin
      if (pcjmp)
        pc <= ir_addr;
      else if (pcinc)
        pc <= pc + 4'h1;
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      cf <= 1'b0;
      zf <= 1'b0;
    end else if (flagsin && !hlt) begin
      cf <= sum9[8];
      zf <= (sum9[7:0] == 8'h00);
    end
  end

  always_comb begin
    step_next = T0;
    hlt       = 1'b0;
    marwa     = 1'b0;
    ramwa     = 1'b0;
    ramoa     = 1'b0;
    inregoa   = 1'b0;
    inregwa   = 1'b0;
    awa       = 1'b0;
    aoa       = 1'b0;
    sumout    = 1'b0;
    sub       = 1'b0;
    bwa       = 1'b0;
    outregwa  = 1'b0;
    pcinc     = 1'b0;
    pcoe      = 1'b0;
    pcjmp     = 1'b0;
    flagsin   = 1'b0;

    case (step_q)
      T0: begin
        step_next = T1;
        pcoe      = 1'b1;
        marwa     = 1'b1;
      end
      T1: begin
        step_next = T2;
        ramoa     = 1'b1;
        inregwa   = 1'b1;
        pcinc     = 1'b1;
      end
      T2, T3, T4: begin
        step_next = (step_q == T4) ? T0 : ((step_q == T2) ? T3 : T4);
        case (opcode)
          4'h1: begin
            inregoa = (step_q == T2);
            marwa   = (step_q == T2);
            ramoa   = (step_q == T3);
            awa     = (step_q == T3);
          end
          4'h2, 4'h3: begin
            inregoa = (step_q == T2);
            marwa   = (step_q == T2);
            ramoa   = (step_q == T3);
            bwa     = (step_q == T3);
            sumout  = (step_q == T4);
            awa     = (step_q == T4);
            flagsin = (step_q == T4);
            sub     = (step_q == T4) && (opcode == 4'h3);
          end
          4'h4: begin
            inregoa = (step_q == T2);
            marwa   = (step_q == T2);
            aoa     = (step_q == T3);
            ramwa   = (step_q == T3);
          end
          4'h5: begin
            inregoa = (step_q == T2);
            awa     = (step_q == T2);
          end
          4'h6: begin
            inregoa = (step_q == T2);
            pcjmp   = (step_q == T2);
          end
          4'h7: begin
            inregoa = (step_q == T2);
            pcjmp   = (step_q == T2) && cf;
          end
          4'h8: begin
            inregoa = (step_q == T2);
            pcjmp   = (step_q == T2) && zf;
          end
          4'hE: begin
            aoa      = (step_q == T2);
            outregwa = (step_q == T2);
          end
          4'hF: hlt = (step_q == T2);
          default: ;
        endcase
        // Halt holds the counter in T2 so hlt stays asserted until clr.
        if (hlt)
          step_next = step_q;
      end
      default: step_next = T0;
    endcase
  end

endmodule

// File: tb/tb_sap_exec_core.sv
// Scoreboard bench for sap_exec_core: stimulus queues expected outputs and
// a monitor process compares them against the DUT whenever a sample is announced.
module tb_sap_exec_core;

  logic       clk;
  logic       clr;
  logic [3:0] opcode;
  logic [3:0] ir_addr;
  logic [7:0] a_val;
  logic [7:0] b_val;
  logic [3:0] pc_bus;
  logic [3:0] pc_val;
  logic [7:0] alu_bus;
  logic       cf, zf;
  logic [2:0] step;
  logic       hlt, marwa, ramwa, ramoa, inregoa, inregwa, awa, aoa;
  logic       sumout, sub, bwa, outregwa, pcinc, pcoe, pcjmp, flagsin;
  logic [15:0] ctrl_word;

  sap_exec_core dut (
    .clk(clk), .clr(clr), .opcode(opcode), .ir_addr(ir_addr),
    .a_val(a_val), .b_val(b_val), .pc_bus(pc_bus), .pc_val(pc_val),
    .alu_bus(alu_bus), .cf(cf), .zf(zf), .step(step),
    .hlt(hlt), .marwa(marwa), .ramwa(ramwa), .ramoa(ramoa),
    .inregoa(inregoa), .inregwa(inregwa), .awa(awa), .aoa(aoa),
    .sumout(sumout), .sub(sub), .bwa(bwa), .outregwa(outregwa),
    .pcinc(pcinc), .pcoe(pcoe), .pcjmp(pcjmp), .flagsin(flagsin)
  );

  assign ctrl_word = {hlt, marwa, ramwa, ramoa, inregoa, inregwa, awa, aoa,
                      sumout, sub, bwa, outregwa, pcinc, pcoe, pcjmp, flagsin};

  localparam logic [15:0] C_HLT = 16'h8000, C_MARWA = 16'h4000, C_RAMWA = 16'h2000,
    C_RAMOA = 16'h1000, C_INREGOA = 16'h0800, C_INREGWA = 16'h0400, C_AWA = 16'h0200,
    C_AOA = 16'h0100, C_SUMOUT = 16'h0080, C_SUB = 16'h0040, C_BWA = 16'h0020,
    C_OUTREGWA = 16'h0010, C_PCINC = 16'h0008, C_PCOE = 16'h0004, C_PCJMP = 16'h0002,
    C_FLAGSIN = 16'h0001;
  localparam logic [15:0] C_FETCH0 = C_PCOE | C_MARWA;
  localparam logic [15:0] C_FETCH1 = C_RAMOA | C_INREGWA | C_PCINC;

  localparam int K_PC = 0, K_STEP = 1, K_CF = 2, K_ZF = 3, K_ALU = 4, K_PCBUS = 5, K_CTRL = 6;

  typedef struct {
    int          kind;
    string       name;
    logic [15:0] exp;
  } exp_t;

  exp_t sbq[$];
  event sample_ev;
  int   checks = 0;
  int   passes = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] actualOf(input int kind);
    case (kind)
      K_PC:    return {12'd0, pc_val};
      K_STEP:  return {13'd0, step};
      K_CF:    return {15'd0, cf};
      K_ZF:    return {15'd0, zf};
      K_ALU:   return {8'd0, alu_bus};
      K_PCBUS: return {12'd0, pc_bus};
      default: return ctrl_word;
    endcase
  endfunction

  // Monitor: drains every queued expectation each time a sample point is announced.
  initial begin
    exp_t        item;
    logic [15:0] act;
    forever begin
      @(sample_ev);
      while (sbq.size() != 0) begin
        item = sbq.pop_front();
        act  = actualOf(item.kind);
        checks++;
        if (act !== item.exp)
          $display("[TB] FAIL %s: got %0h expected %0h", item.name, act, item.exp);
        else
          passes++;
      end
    end
  end

  task automatic applyStimulus(input logic [3:0] op, input logic [3:0] addr,
                               input logic [7:0] a, input logic [7:0] b);
    opcode  = op;
    ir_addr = addr;
    a_val   = a;
    b_val   = b;
  endtask

  task automatic checkOutput(input int kind, input string name, input logic [15:0] exp);
    exp_t item;
    item.kind = kind;
    item.name = name;
    item.exp  = exp;
    sbq.push_back(item);
  endtask

  task automatic sampleNow();
    ->sample_ev;
    #0;
  endtask

  task automatic waitFall();
    @(negedge clk);
    #1;
  endtask

  task automatic waitRise();
    @(posedge clk);
    #1;
  endtask

  // Runs one full instruction starting just inside T0, checking each T-state.
  task automatic runInstr(input string tag, input logic [3:0] op, input logic [3:0] addr,
                          input logic [7:0] a, input logic [7:0] b,
                          input logic [15:0] t2, input logic [15:0] t3, input logic [15:0] t4,
                          input logic [3:0] pc_start, input logic [3:0] pc_end,
                          input logic [7:0] alu, input logic cf_e, input logic zf_e);
    logic [3:0] pc_inc;
    pc_inc = pc_start + 4'd1;
    applyStimulus(op, addr, a, b);
    checkOutput(K_STEP, {tag, "_t0_step"}, 16'd0);
    checkOutput(K_CTRL, {tag, "_t0_ctrl"}, C_FETCH0);
    checkOutput(K_PCBUS, {tag, "_t0_pc_bus"}, {12'd0, pc_start});
    sampleNow();
    waitFall();
    checkOutput(K_STEP, {tag, "_t1_step"}, 16'd1);
    checkOutput(K_CTRL, {tag, "_t1_ctrl"}, C_FETCH1);
    checkOutput(K_PCBUS, {tag, "_t1_pc_bus"}, 16'd0);
    checkOutput(K_PC, {tag, "_t1_pc"}, {12'd0, pc_start});
    sampleNow();
    waitFall();
    checkOutput(K_STEP, {tag, "_t2_step"}, 16'd2);
    checkOutput(K_CTRL, {tag, "_t2_ctrl"}, t2);
    checkOutput(K_PC, {tag, "_t2_pc"}, {12'd0, pc_inc});
    sampleNow();
    waitFall();
    checkOutput(K_STEP, {tag, "_t3_step"}, 16'd3);
    checkOutput(K_CTRL, {tag, "_t3_ctrl"}, t3);
    sampleNow();
    waitFall();
    checkOutput(K_STEP, {tag, "_t4_step"}, 16'd4);
    checkOutput(K_CTRL, {tag, "_t4_ctrl"}, t4);
    checkOutput(K_PC, {tag, "_t4_pc"}, {12'd0, pc_end});
    checkOutput(K_ALU, {tag, "_t4_alu"}, {8'd0, alu});
    sampleNow();
    waitRise();
    checkOutput(K_CF, {tag, "_cf"}, {15'd0, cf_e});
    checkOutput(K_ZF, {tag, "_zf"}, {15'd0, zf_e});
    sampleNow();
    waitFall();
  endtask

  localparam logic [15:0] C_ADD4 = C_SUMOUT | C_AWA | C_FLAGSIN;
  localparam logic [15:0] C_MEM2 = C_INREGOA | C_MARWA;

  initial begin
    clr = 1'b1;
    applyStimulus(4'h0, 4'h0, 8'h00, 8'h00);
    #2 clr = 1'b0;
    #1;
    checkOutput(K_PC, "rst_pc", 16'd0);
    checkOutput(K_STEP, "rst_step", 16'd0);
    checkOutput(K_CF, "rst_cf", 16'd0);
    checkOutput(K_ZF, "rst_zf", 16'd0);
    checkOutput(K_CTRL, "rst_ctrl", C_FETCH0);
    checkOutput(K_PCBUS, "rst_pc_bus", 16'd0);
    checkOutput(K_ALU, "rst_alu", 16'd0);
    sampleNow();
    #9 clr = 1'b1;
    #1;

    runInstr("add_ff_01", 4'h2, 4'h0, 8'hFF, 8'h01, C_MEM2, C_RAMOA | C_BWA, C_ADD4,
             4'h0, 4'h1, 8'h00, 1'b1, 1'b1);
    runInstr("sub_05_07", 4'h3, 4'h0, 8'h05, 8'h07, C_MEM2, C_RAMOA | C_BWA, C_ADD4 | C_SUB,
             4'h1, 4'h2, 8'hFE, 1'b0, 1'b0);
    runInstr("jc_not", 4'h7, 4'hA, 8'h55, 8'h22, C_INREGOA, 16'h0, 16'h0,
             4'h2, 4'h3, 8'h00, 1'b0, 1'b0);
    runInstr("sub_07_07", 4'h3, 4'h0, 8'h07, 8'h07, C_MEM2, C_RAMOA | C_BWA, C_ADD4 | C_SUB,
             4'h3, 4'h4, 8'h00, 1'b1, 1'b1);
    runInstr("jc_taken", 4'h7, 4'hA, 8'h55, 8'h22, C_INREGOA | C_PCJMP, 16'h0, 16'h0,
             4'h4, 4'hA, 8'h00, 1'b1, 1'b1);
    runInstr("jmp_f", 4'h6, 4'hF, 8'h55, 8'h22, C_INREGOA | C_PCJMP, 16'h0, 16'h0,
             4'hA, 4'hF, 8'h00, 1'b1, 1'b1);
    runInstr("nop_wrap", 4'h0, 4'h3, 8'h55, 8'h22, 16'h0, 16'h0, 16'h0,
             4'hF, 4'h0, 8'h00, 1'b1, 1'b1);
    runInstr("jz_taken", 4'h8, 4'h7, 8'h55, 8'h22, C_INREGOA | C_PCJMP, 16'h0, 16'h0,
             4'h0, 4'h7, 8'h00, 1'b1, 1'b1);
    runInstr("unused_a", 4'hA, 4'h2, 8'h55, 8'h22, 16'h0, 16'h0, 16'h0,
             4'h7, 4'h8, 8'h00, 1'b1, 1'b1);
    runInstr("ldi", 4'h5, 4'h2, 8'h55, 8'h22, C_INREGOA | C_AWA, 16'h0, 16'h0,
             4'h8, 4'h9, 8'h00, 1'b1, 1'b1);
    runInstr("sta", 4'h4, 4'h2, 8'h55, 8'h22, C_MEM2, C_AOA | C_RAMWA, 16'h0,
             4'h9, 4'hA, 8'h00, 1'b1, 1'b1);
    runInstr("out", 4'hE, 4'h2, 8'h55, 8'h22, C_AOA | C_OUTREGWA, 16'h0, 16'h0,
             4'hA, 4'hB, 8'h00, 1'b1, 1'b1);
    runInstr("lda", 4'h1, 4'h2, 8'h55, 8'h22, C_MEM2, C_RAMOA | C_AWA, 16'h0,
             4'hB, 4'hC, 8'h00, 1'b1, 1'b1);
    runInstr("add_80_90", 4'h2, 4'h0, 8'h80, 8'h90, C_MEM2, C_RAMOA | C_BWA, C_ADD4,
             4'hC, 4'hD, 8'h10, 1'b1, 1'b0);

    applyStimulus(4'hF, 4'h0, 8'h01, 8'h01);
    waitFall();
    waitFall();
    checkOutput(K_CTRL, "hlt_t2_ctrl", C_HLT);
    checkOutput(K_PC, "hlt_t2_pc", 16'hE);
    sampleNow();
    repeat (20) waitFall();
    checkOutput(K_STEP, "hlt_frozen_step", 16'd2);
    checkOutput(K_PC, "hlt_frozen_pc", 16'hE);
    checkOutput(K_CTRL, "hlt_frozen_ctrl", C_HLT);
    checkOutput(K_CF, "hlt_frozen_cf", 16'd1);
    checkOutput(K_ZF, "hlt_frozen_zf", 16'd0);
    sampleNow();

    #1 clr = 1'b0;
    #1;
    checkOutput(K_PC, "clr_pc", 16'd0);
    checkOutput(K_STEP, "clr_step", 16'd0);
    checkOutput(K_CTRL, "clr_ctrl", C_FETCH0);
    checkOutput(K_CF, "clr_cf", 16'd0);
    sampleNow();
    #1 clr = 1'b1;

    runInstr("post_clr_unused", 4'hA, 4'h5, 8'hFF, 8'h01, 16'h0, 16'h0, 16'h0,
             4'h0, 4'h1, 8'h00, 1'b0, 1'b0);

    #2;
    if (sbq.size() != 0) begin
      checks++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending expected 0", sbq.size());
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/sap_exec_core.md
# sap_exec_core

Execution core of the 8-bit SAP-style board computer. It contains three parts:
- the 4-bit program counter;
- the 8-bit add/subtract ALU with latched carry/zero flags;
- the 3-bit microstep counter and the microcode control unit that drives every register-enable strobe on the shared bus.

Registers, RAM, MAR, IR and the output register sit outside this block. They are steered only by its control outputs.

## Interface
Parameters: none.
- clk  in  1  system clock; PC and flags on rising edge, microstep counter on falling edge
- clr  in  1  reset, asynchronous, active-low
- opcode  in  4  instruction register bits [7:4]
- ir_addr  in  4  instruction register bits [3:0], the jump target
- a_val  in  8  A register contents
- b_val  in  8  B register contents
- pc_bus  out  4  PC value when pcoe=1, else 4'h0
- pc_val  out  4  PC value, unconditional
- alu_bus  out  8  ALU result when sumout=1, else 8'h00
- cf, zf  out  1 each  latched carry and zero flags
- step  out  3  current microstep
- hlt, marwa, ramwa, ramoa, inregoa, inregwa, awa, aoa, sumout, sub, bwa, outregwa, pcinc, pcoe, pcjmp, flagsin  out  1 each  control strobes, combinational from {opcode, step, cf, zf}

## Operation
ALU (combinational):
- sum9 = a_val + (sub ? ~b_val : b_val) + sub, as a 9-bit result.
- Result = sum9[7:0]; carry = sum9[8]. On SUB, carry=1 means no borrow.

Flags:
- On a rising edge with flagsin=1: cf←carry, zf←(result==0).
- Otherwise cf and zf hold.

Program counter:
- On a rising edge, pcjmp=1 loads ir_addr. pcjmp has priority over pcinc.
- Otherwise pcinc=1 increments, wrapping 4'hF→4'h0.
- Otherwise the PC holds.

Microstep counter:
- Advances on the falling edge of clk: 0→1→2→3→4→0 (5 T-states).
- Values 5–7 are never reached. If one appears, the next falling edge forces 0.

Control strobes: any strobe not listed below is 0.
- Fetch, every opcode:
  - T0: pcoe, marwa
  - T1: ramoa, inregwa, pcinc
- T2–T4 by opcode:
  - 0000 NOP: none
  - 0001 LDA: T2 inregoa, marwa; T3 ramoa, awa
  - 0010 ADD: T2 inregoa, marwa; T3 ramoa, bwa; T4 sumout, awa, flagsin
  - 0011 SUB: as ADD, plus sub in T4
  - 0100 STA: T2 inregoa, marwa; T3 aoa, ramwa
  - 0101 LDI: T2 inregoa, awa
  - 0110 JMP: T2 inregoa, pcjmp
  - 0111 JC: T2 inregoa, plus pcjmp only if cf=1
  - 1000 JZ: T2 inregoa, plus pcjmp only if zf=1
  - 1110 OUT: T2 aoa, outregwa
  - 1111 HLT: T2 hlt
  - All other opcodes: treated as NOP
- sub is 0 whenever sumout is 0.

Halt:
- While hlt=1, the PC, flags and microstep counter freeze, so hlt stays asserted.
- Only clr releases the halt.

## Timing
- Reset (clr=0, asynchronous): pc=0, step=0, cf=0, zf=0.
  - Resulting outputs: T0 strobes active (pcoe=1, marwa=1), pc_bus=0, alu_bus=0.
- Strobes change only after a falling edge, or after a change in opcode or flags. They are therefore stable across the following rising edge.
- Rising-edge register writes all use the strobe values from the preceding half-cycle. A strobe asserted in step n takes effect at the rising edge inside step n.
- Instruction length is 5 clock cycles for every opcode, including NOP and jumps not taken.
- Reset asserted mid-instruction aborts it immediately. Flags do not update at that edge.
- flagsin and pcjmp in the same cycle cannot occur. JC and JZ sample the flags latched by an earlier instruction.

## Test plan
- Reset then release: pc=0, step=0, T0 strobes pcoe+marwa. One falling edge → T1 strobes. Rising edge in T1 → pc=1.
- ADD with a_val=8'hFF, b_val=8'h01, opcode=0010 at T4: alu_bus=8'h00, flagsin=1. Next rising edge → cf=1, zf=1.
- SUB with a_val=8'h05, b_val=8'h07: result 8'hFE, cf=0, zf=0. Then a_val=8'h07, b_val=8'h07: cf=1, zf=1.
- JC with cf=0, ir_addr=4'hA: no pcjmp, pc unchanged at T2. Set cf=1 and repeat: pc=4'hA after T2.
- PC at 4'hF with pcinc → 4'h0. pcjmp and pcinc in the same cycle → ir_addr is loaded.
- HLT at T2: hlt=1, step and pc frozen for 20 cycles. clr pulse → pc=0, step=0, hlt=0. Unused opcode 1010 → no strobes in T2–T4.
